// File: rtl/mem_stage_pkg.sv
// Shared types for the memory stage: pipeline register payloads, load funct3 codes
// and the data-memory handshake state.
package mem_stage_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned MASKW = XLEN / 8;
    localparam int unsigned REGW  = 5;

    localparam logic [2:0] load_f3_lb  = 3'b000;
    localparam logic [2:0] load_f3_lh  = 3'b001;
    localparam logic [2:0] load_f3_lw  = 3'b010;
    localparam logic [2:0] load_f3_lbu = 3'b100;
    localparam logic [2:0] load_f3_lhu = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    // Retirement record carried down the pipe
    typedef struct packed {
        logic             valid;
        logic [XLEN-1:0]  inst;
        logic [XLEN-1:0]  pc_rdata;
        logic [REGW-1:0]  rd_addr;
        logic [XLEN-1:0]  rd_wdata;
        logic [XLEN-1:0]  mem_addr;
        logic [MASKW-1:0] mem_rmask;
        logic [MASKW-1:0] mem_wmask;
        logic [XLEN-1:0]  mem_rdata;
        logic [XLEN-1:0]  mem_wdata;
    } rvfi_data_t;

    typedef struct packed {
        rvfi_data_t  rvfi_data;
        logic [1:0]  bottom_two;
        logic        j;
        logic        mem_inst;
    } ex_mm_stage_reg_t;

    typedef struct packed {
        rvfi_data_t  rvfi_data;
        logic        j;
    } mm_wb_stage_reg_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: selects the addressed byte/halfword of a read word and
// sign- or zero-extends it according to the load funct3.
//  rdata    in  32  raw word returned by data memory
//  funct3   in  3   load width/sign code
//  off      in  2   byte offset of the access within the word
//  rd_wdata out 32  value to write to the destination register (combinational)
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      funct3,
    input  logic [1:0]      off,
    output logic [XLEN-1:0] rd_wdata
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'(rdata >> {off, 3'b000});
        half_sel = 16'(rdata >> {off[1], 4'b0000});
        rd_wdata = rdata;
        case (funct3)
            load_f3_lb:  rd_wdata = {{24{byte_sel[7]}}, byte_sel};
            load_f3_lbu: rd_wdata = {24'd0, byte_sel};
            load_f3_lh:  rd_wdata = {{16{half_sel[15]}}, half_sel};
            load_f3_lhu: rd_wdata = {16'd0, half_sel};
            load_f3_lw:  rd_wdata = rdata;
            default:     rd_wdata = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage of the rv32i pipeline: EX/MEM register, data-memory request/response
// handshake, load alignment and the MEM/WB register.
//  clk, rst_n  clock and asynchronous active-low reset
//  ex_mm_i     execute result entering EX/MEM (ignored while stall_o=1)
//  stall_o     combinational hold request for the upstream stages
//  mm_o        EX/MEM register (forwarding source)
//  wb_o        MEM/WB register (forwarding source, to writeback)
//  dmem_*      data-memory request (addr/masks/wdata) and response (rdata/resp)
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  ex_mm_stage_reg_t ex_mm_i,
    output logic             stall_o,
    output ex_mm_stage_reg_t mm_o,
    output mm_wb_stage_reg_t wb_o,
    output logic [XLEN-1:0]  dmem_addr,
    output logic [MASKW-1:0] dmem_rmask,
    output logic [MASKW-1:0] dmem_wmask,
    output logic [XLEN-1:0]  dmem_wdata,
    input  logic [XLEN-1:0]  dmem_rdata,
    input  logic             dmem_resp
);

    mem_state_t       state;
    mem_state_t       state_next;
    logic             mem_req;
    logic [XLEN-1:0]  aligned;
    mm_wb_stage_reg_t wb_next;

    assign mem_req = mm_o.rvfi_data.valid && mm_o.mem_inst;

    // Handshake state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Issue in IDLE for one cycle, then wait for the response pulse
    always_comb begin
        state_next = state;
        stall_o    = 1'b0;
        dmem_rmask = '0;
        dmem_wmask = '0;
        dmem_addr  = {mm_o.rvfi_data.mem_addr[XLEN-1:2], 2'b00};
        dmem_wdata = mm_o.rvfi_data.mem_wdata;
        case (state)
            IDLE: begin
                if (mem_req) begin
                    stall_o    = 1'b1;
                    dmem_rmask = mm_o.rvfi_data.mem_rmask;
                    dmem_wmask = mm_o.rvfi_data.mem_wmask;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (dmem_resp) begin
                    state_next = IDLE;
                end else begin
                    stall_o = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    mem_stage_load_align u_load_align (
        .rdata    (dmem_rdata),
        .funct3   (mm_o.rvfi_data.inst[14:12]),
        .off      (mm_o.bottom_two),
        .rd_wdata (aligned)
    );

    // Retirement record; only the response cycle in WAIT can reach here unstalled
    always_comb begin
        wb_next.rvfi_data = mm_o.rvfi_data;
        wb_next.j         = mm_o.j;
        if (state == WAIT) begin
            wb_next.rvfi_data.mem_rdata = dmem_rdata;
            if (mm_o.rvfi_data.mem_rmask != '0) begin
                wb_next.rvfi_data.rd_wdata = (mm_o.rvfi_data.rd_addr == '0) ? '0 : aligned;
            end else begin
                wb_next.rvfi_data.rd_wdata = '0;
                wb_next.rvfi_data.rd_addr  = '0;
            end
        end
    end

    // Pipeline registers; a stall holds EX/MEM and drops a bubble into MEM/WB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mm_o <= '0;
            wb_o <= '0;
        end else if (stall_o) begin
            wb_o.rvfi_data.valid <= 1'b0;
        end else begin
            mm_o <= ex_mm_i;
            wb_o <= wb_next;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus a randomized stream
// checked against a transaction-level reference model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n;
    ex_mm_stage_reg_t ex_mm_i;
    logic             stall_o;
    ex_mm_stage_reg_t mm_o;
    mm_wb_stage_reg_t wb_o;
    logic [31:0]      dmem_addr;
    logic [3:0]       dmem_rmask;
    logic [3:0]       dmem_wmask;
    logic [31:0]      dmem_wdata;
    logic [31:0]      dmem_rdata;
    logic             dmem_resp;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } mreq_t;

    mem_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ex_mm_i    (ex_mm_i),
        .stall_o    (stall_o),
        .mm_o       (mm_o),
        .wb_o       (wb_o),
        .dmem_addr  (dmem_addr),
        .dmem_rmask (dmem_rmask),
        .dmem_wmask (dmem_wmask),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_resp  (dmem_resp)
    );

    always #5 clk = ~clk;

    // Reference load extraction using plain arithmetic on the word
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] rdata);
        longint v;
        int     bsh;
        int     hsh;
        bsh = 8 * int'(off);
        hsh = 16 * int'(off[1]);
        case (f3)
            3'b000: begin
                v = longint'((rdata >> bsh) % 256);
                if (v >= 128) v = v - 256;
                return 32'(v);
            end
            3'b100: return (rdata >> bsh) % 256;
            3'b001: begin
                v = longint'((rdata >> hsh) % 65536);
                if (v >= 32768) v = v - 65536;
                return 32'(v);
            end
            3'b101: return (rdata >> hsh) % 65536;
            default: return rdata;
        endcase
    endfunction

    // Expected retirement record for one instruction
    function automatic mm_wb_stage_reg_t exp_wb(input ex_mm_stage_reg_t t, input logic [31:0] rdata);
        mm_wb_stage_reg_t w;
        w.rvfi_data = t.rvfi_data;
        w.j         = t.j;
        if (t.mem_inst) begin
            w.rvfi_data.mem_rdata = rdata;
            if (t.rvfi_data.mem_rmask != 4'd0) begin
                w.rvfi_data.rd_wdata = (t.rvfi_data.rd_addr == 5'd0) ? 32'd0 :
                    ref_load(t.rvfi_data.inst[14:12], t.bottom_two, rdata);
            end else begin
                w.rvfi_data.rd_wdata = 32'd0;
                w.rvfi_data.rd_addr  = 5'd0;
            end
        end
        return w;
    endfunction

    function automatic ex_mm_stage_reg_t mk_alu(input logic [4:0] rd, input logic [31:0] val);
        ex_mm_stage_reg_t t;
        t = '0;
        t.rvfi_data.valid    = 1'b1;
        t.rvfi_data.inst     = {17'($urandom), 3'b000, rd, 7'b0010011};
        t.rvfi_data.pc_rdata = $urandom;
        t.rvfi_data.rd_addr  = rd;
        t.rvfi_data.rd_wdata = val;
        t.j                  = 1'($urandom);
        return t;
    endfunction

    function automatic ex_mm_stage_reg_t mk_load(input logic [2:0] f3, input logic [31:0] addr,
                                                 input logic [4:0] rd);
        ex_mm_stage_reg_t t;
        t = '0;
        t.rvfi_data.valid    = 1'b1;
        t.rvfi_data.inst     = {17'($urandom), f3, rd, 7'b0000011};
        t.rvfi_data.pc_rdata = $urandom;
        t.rvfi_data.rd_addr  = rd;
        t.rvfi_data.rd_wdata = $urandom;
        t.rvfi_data.mem_addr = addr;
        case (f3[1:0])
            2'b00:   t.rvfi_data.mem_rmask = 4'b0001 << addr[1:0];
            2'b01:   t.rvfi_data.mem_rmask = 4'b0011 << addr[1:0];
            default: t.rvfi_data.mem_rmask = 4'b1111;
        endcase
        t.bottom_two = addr[1:0];
        t.mem_inst   = 1'b1;
        return t;
    endfunction

    function automatic ex_mm_stage_reg_t mk_store(input logic [31:0] addr, input logic [31:0] wdata,
                                                  input logic [3:0] wmask, input logic [4:0] rd);
        ex_mm_stage_reg_t t;
        t = '0;
        t.rvfi_data.valid     = 1'b1;
        t.rvfi_data.inst      = {17'($urandom), 3'b010, rd, 7'b0100011};
        t.rvfi_data.pc_rdata  = $urandom;
        t.rvfi_data.rd_addr   = rd;
        t.rvfi_data.rd_wdata  = $urandom;
        t.rvfi_data.mem_addr  = addr;
        t.rvfi_data.mem_wmask = wmask;
        t.rvfi_data.mem_wdata = wdata;
        t.bottom_two          = addr[1:0];
        t.mem_inst            = 1'b1;
        return t;
    endfunction

    function automatic ex_mm_stage_reg_t rand_txn();
        ex_mm_stage_reg_t t;
        logic [2:0]  f3s [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic [2:0]  f3;
        logic [31:0] a;
        int          k;
        int          sz;
        k = $urandom_range(0, 9);
        a = $urandom;
        if (k < 2) begin
            t = mk_load(3'b010, a & 32'hFFFF_FFFC, 5'($urandom_range(0, 31)));
            t.mem_inst        = 1'($urandom);
            t.rvfi_data.valid = 1'b0;
        end else if (k < 5) begin
            t = mk_alu(5'($urandom_range(0, 31)), $urandom);
        end else if (k < 8) begin
            f3 = f3s[$urandom_range(0, 4)];
            if (f3[1:0] == 2'b01) a[0] = 1'b0;
            if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
            t = mk_load(f3, a, 5'($urandom_range(0, 31)));
        end else begin
            sz = $urandom_range(0, 2);
            if (sz == 0) begin
                t = mk_store(a, $urandom, 4'b0001 << a[1:0], 5'($urandom_range(0, 31)));
            end else if (sz == 1) begin
                a[0] = 1'b0;
                t = mk_store(a, $urandom, 4'b0011 << a[1:0], 5'($urandom_range(0, 31)));
            end else begin
                a[1:0] = 2'b00;
                t = mk_store(a, $urandom, 4'b1111, 5'($urandom_range(0, 31)));
            end
        end
        return t;
    endfunction

    task automatic flush(input int n);
        ex_mm_i   = '0;
        dmem_resp = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents one memory op, answers it 'delay' cycles after the issue cycle,
    // and collects what the memory port and MEM/WB register showed.
    task automatic run_mem(input ex_mm_stage_reg_t t, input int delay, input logic [31:0] rdata,
                           output mm_wb_stage_reg_t got, output int stalls, output int rpulse,
                           output int wpulse, output logic [31:0] iss_addr,
                           output logic [31:0] iss_wdata, output logic [3:0] iss_wmask);
        stalls = 0; rpulse = 0; wpulse = 0;
        iss_addr = '0; iss_wdata = '0; iss_wmask = '0;
        ex_mm_i   = t;
        dmem_resp = 1'b0;
        @(posedge clk);
        #1;
        ex_mm_i = '0;
        for (int c = 0; c <= delay; c++) begin
            dmem_resp  = (c == delay);
            dmem_rdata = (c == delay) ? rdata : $urandom;
            @(negedge clk);
            if (stall_o) stalls++;
            if (dmem_rmask != 4'd0) begin
                rpulse++;
                iss_addr = dmem_addr;
            end
            if (dmem_wmask != 4'd0) begin
                wpulse++;
                iss_addr  = dmem_addr;
                iss_wdata = dmem_wdata;
                iss_wmask = dmem_wmask;
            end
            @(posedge clk);
            #1;
        end
        dmem_resp = 1'b0;
        @(negedge clk);
        got = wb_o;
    endtask

    // Streams entries with no memory ops; each must reach wb_o exactly 2 edges later
    task automatic run_alu_stream(input string name, input ex_mm_stage_reg_t s[$], input logic resp_on);
        int n;
        mm_wb_stage_reg_t e;
        n = s.size();
        for (int k = 1; k <= n + 3; k++) begin
            if (k - 1 < n) ex_mm_i = s[k-1];
            else           ex_mm_i = '0;
            dmem_resp  = resp_on;
            dmem_rdata = $urandom;
            @(posedge clk);
            #1;
            @(negedge clk);
            n_cmp++;
            if (stall_o !== 1'b0) begin
                n_bad++;
                $display("FAIL %s stall k=%0d: got %b want 0", name, k, stall_o);
            end
            if (k >= 2 && k - 2 < n) begin
                e = exp_wb(s[k-2], 32'd0);
                n_cmp++;
                if (wb_o !== e) begin
                    n_bad++;
                    $display("FAIL %s wb k=%0d: got %h want %h", name, k, wb_o, e);
                end
            end else begin
                n_cmp++;
                if (wb_o.rvfi_data.valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL %s wb_valid k=%0d: got %b want 0", name, k, wb_o.rvfi_data.valid);
                end
            end
        end
        dmem_resp = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ex_mm_i = '0; dmem_resp = 1'b0; dmem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (wb_o !== '0 || mm_o !== '0 || stall_o !== 1'b0 || dmem_rmask !== 4'd0 || dmem_wmask !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_state: got wb=%h mm=%h stall=%b rm=%h wm=%h want all 0",
                     wb_o, mm_o, stall_o, dmem_rmask, dmem_wmask);
        end
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        ex_mm_i = mk_load(3'b010, 32'h0000_0040, 5'd4);
        @(posedge clk);
        #1;
        ex_mm_i = '0;
        @(negedge clk);
        n_cmp++;
        if (dmem_rmask !== 4'hF) begin
            n_bad++;
            $display("FAIL reset_issue: got rmask %h want f", dmem_rmask);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++;
        if (stall_o !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_waiting: got stall %b want 1", stall_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (wb_o.rvfi_data.valid !== 1'b0 || mm_o.rvfi_data.valid !== 1'b0 || stall_o !== 1'b0 ||
            dmem_rmask !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_mid_wait: got wbv=%b mmv=%b stall=%b rm=%h want 0 0 0 0",
                     wb_o.rvfi_data.valid, mm_o.rvfi_data.valid, stall_o, dmem_rmask);
        end
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        dmem_resp  = 1'b1;
        dmem_rdata = 32'h1234_5678;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (stall_o !== 1'b0 || wb_o.rvfi_data.valid !== 1'b0 || dmem_rmask !== 4'd0) begin
                n_bad++;
                $display("FAIL reset_late_resp k=%0d: got stall=%b wbv=%b rm=%h want 0 0 0",
                         k, stall_o, wb_o.rvfi_data.valid, dmem_rmask);
            end
            @(posedge clk);
            #1;
            dmem_resp = 1'b0;
        end
    endtask

    task automatic test_alu();
        ex_mm_stage_reg_t s[$];
        s.push_back(mk_alu(5'd1, 32'd5));
        s.push_back('0);
        run_alu_stream("alu", s, 1'b0);
    endtask

    task automatic test_load_byte();
        mm_wb_stage_reg_t got;
        int st, rp, wp;
        logic [31:0] ia, iw;
        logic [3:0]  im;
        run_mem(mk_load(3'b000, 32'h0000_0202, 5'd3), 4, 32'h0080_0000, got, st, rp, wp, ia, iw, im);
        n_cmp++;
        if (st !== 4) begin n_bad++; $display("FAIL lb_stall_cycles: got %0d want 4", st); end
        n_cmp++;
        if (rp !== 1 || wp !== 0) begin n_bad++; $display("FAIL lb_pulses: got r%0d w%0d want r1 w0", rp, wp); end
        n_cmp++;
        if (ia !== 32'h0000_0200) begin n_bad++; $display("FAIL lb_addr: got %h want 00000200", ia); end
        n_cmp++;
        if (got.rvfi_data.valid !== 1'b1 || got.rvfi_data.rd_wdata !== 32'hFFFF_FF80 ||
            got.rvfi_data.rd_addr !== 5'd3 || got.rvfi_data.mem_rdata !== 32'h0080_0000) begin
            n_bad++;
            $display("FAIL lb_wb: got v=%b rd=%0d wd=%h mr=%h want 1 3 ffffff80 00800000",
                     got.rvfi_data.valid, got.rvfi_data.rd_addr, got.rvfi_data.rd_wdata,
                     got.rvfi_data.mem_rdata);
        end
    endtask

    task automatic test_load_half_word();
        mm_wb_stage_reg_t got;
        int st, rp, wp;
        logic [31:0] ia, iw;
        logic [3:0]  im;
        run_mem(mk_load(3'b101, 32'h0000_0302, 5'd9), $urandom_range(1, 3), 32'h8001_1234,
                got, st, rp, wp, ia, iw, im);
        n_cmp++;
        if (got.rvfi_data.valid !== 1'b1 || got.rvfi_data.rd_wdata !== 32'h0000_8001) begin
            n_bad++;
            $display("FAIL lhu_wb: got v=%b wd=%h want 1 00008001", got.rvfi_data.valid, got.rvfi_data.rd_wdata);
        end
        run_mem(mk_load(3'b010, 32'h0000_0400, 5'd10), $urandom_range(1, 3), 32'hDEAD_BEEF,
                got, st, rp, wp, ia, iw, im);
        n_cmp++;
        if (got.rvfi_data.valid !== 1'b1 || got.rvfi_data.rd_wdata !== 32'hDEAD_BEEF) begin
            n_bad++;
            $display("FAIL lw_wb: got v=%b wd=%h want 1 deadbeef", got.rvfi_data.valid, got.rvfi_data.rd_wdata);
        end
    endtask

    task automatic test_store();
        mm_wb_stage_reg_t got;
        int st, rp, wp;
        logic [31:0] ia, iw;
        logic [3:0]  im;
        run_mem(mk_store(32'h0000_0100, 32'hCAFE_F00D, 4'hF, 5'd7), 1, 32'h5555_AAAA,
                got, st, rp, wp, ia, iw, im);
        n_cmp++;
        if (st !== 1 || wp !== 1 || rp !== 0) begin
            n_bad++;
            $display("FAIL sw_handshake: got stall=%0d w=%0d r=%0d want 1 1 0", st, wp, rp);
        end
        n_cmp++;
        if (im !== 4'hF || ia !== 32'h0000_0100 || iw !== 32'hCAFE_F00D) begin
            n_bad++;
            $display("FAIL sw_request: got m=%h a=%h d=%h want f 00000100 cafef00d", im, ia, iw);
        end
        n_cmp++;
        if (got.rvfi_data.valid !== 1'b1 || got.rvfi_data.rd_addr !== 5'd0 ||
            got.rvfi_data.rd_wdata !== 32'd0 || got.rvfi_data.mem_wdata !== 32'hCAFE_F00D) begin
            n_bad++;
            $display("FAIL sw_wb: got v=%b rd=%0d wd=%h md=%h want 1 0 0 cafef00d", got.rvfi_data.valid,
                     got.rvfi_data.rd_addr, got.rvfi_data.rd_wdata, got.rvfi_data.mem_wdata);
        end
    endtask

    task automatic test_spurious_resp();
        ex_mm_stage_reg_t s[$];
        for (int i = 0; i < 5; i++) s.push_back(mk_alu(5'($urandom_range(1, 31)), $urandom));
        run_alu_stream("spurious", s, 1'b1);
    endtask

    // Random stream with a randomly delayed responder and spurious idle responses
    task automatic test_random(input int ntx);
        ex_mm_stage_reg_t txq[$];
        mm_wb_stage_reg_t wbq[$];
        mreq_t            mq[$];
        logic [31:0]      rq[$];
        ex_mm_stage_reg_t t;
        mm_wb_stage_reg_t e;
        mreq_t            m;
        logic [31:0]      rd;
        logic [31:0]      rcur;
        logic             pending;
        logic             is_issue;
        logic             st;
        logic             exp_stall;
        int               cnt;
        int               idx;
        int               cyc;
        int               n_exp;
        int               n_got;
        for (int i = 0; i < ntx; i++) begin
            t = rand_txn();
            txq.push_back(t);
            if (t.rvfi_data.valid) begin
                rd = $urandom;
                if (t.mem_inst) begin
                    rq.push_back(rd);
                    m.addr  = t.rvfi_data.mem_addr & 32'hFFFF_FFFC;
                    m.rmask = t.rvfi_data.mem_rmask;
                    m.wmask = t.rvfi_data.mem_wmask;
                    m.wdata = t.rvfi_data.mem_wdata;
                    mq.push_back(m);
                end
                wbq.push_back(exp_wb(t, rd));
            end
        end
        n_exp = wbq.size();
        n_got = 0; idx = 0; cyc = 0; pending = 1'b0; cnt = 0; rcur = '0;
        ex_mm_i = txq[0]; dmem_resp = 1'b0;
        while (!(idx >= ntx && wbq.size() == 0 && !pending) && cyc < 20000) begin
            cyc++;
            @(negedge clk);
            is_issue = (dmem_rmask != 4'd0) || (dmem_wmask != 4'd0);
            if (is_issue) begin
                exp_stall = 1'b1;
                n_cmp++;
                if (pending || mq.size() == 0) begin
                    n_bad++;
                    $display("FAIL rand_issue_unexpected cyc=%0d: got issue pending=%b left=%0d",
                             cyc, pending, mq.size());
                end else begin
                    m = mq.pop_front();
                    if (dmem_addr !== m.addr || dmem_rmask !== m.rmask || dmem_wmask !== m.wmask ||
                        (m.wmask != 4'd0 && dmem_wdata !== m.wdata)) begin
                        n_bad++;
                        $display("FAIL rand_issue cyc=%0d: got a=%h r=%h w=%h d=%h want a=%h r=%h w=%h d=%h",
                                 cyc, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
                                 m.addr, m.rmask, m.wmask, m.wdata);
                    end
                end
            end else if (pending) begin
                exp_stall = !dmem_resp;
            end else begin
                exp_stall = 1'b0;
            end
            n_cmp++;
            if (stall_o !== exp_stall) begin
                n_bad++;
                $display("FAIL rand_stall cyc=%0d: got %b want %b", cyc, stall_o, exp_stall);
            end
            if (wb_o.rvfi_data.valid === 1'b1) begin
                n_got++;
                n_cmp++;
                if (wbq.size() == 0) begin
                    n_bad++;
                    $display("FAIL rand_extra_commit cyc=%0d: got %h want none", cyc, wb_o);
                end else begin
                    e = wbq.pop_front();
                    if (wb_o !== e) begin
                        n_bad++;
                        $display("FAIL rand_wb cyc=%0d: got %h want %h", cyc, wb_o, e);
                    end
                end
            end
            st = stall_o;
            @(posedge clk);
            #1;
            if (pending && dmem_resp) pending = 1'b0;
            if (is_issue) begin
                pending = 1'b1;
                cnt     = $urandom_range(0, 3);
                rcur    = (rq.size() != 0) ? rq.pop_front() : 32'd0;
            end
            if (!st) idx++;
            if (idx < ntx) ex_mm_i = txq[idx];
            else           ex_mm_i = '0;
            if (pending) begin
                if (cnt == 0) begin
                    dmem_resp  = 1'b1;
                    dmem_rdata = rcur;
                end else begin
                    dmem_resp  = 1'b0;
                    dmem_rdata = $urandom;
                    cnt--;
                end
            end else begin
                dmem_resp  = ($urandom_range(0, 3) == 0);
                dmem_rdata = $urandom;
            end
        end
        dmem_resp = 1'b0;
        n_cmp++;
        if (cyc >= 20000) begin
            n_bad++;
            $display("FAIL rand_timeout: got idx=%0d left=%0d want stream drained", idx, wbq.size());
        end
        n_cmp++;
        if (n_got !== n_exp || mq.size() != 0) begin
            n_bad++;
            $display("FAIL rand_commit_count: got %0d commits, %0d unissued want %0d, 0",
                     n_got, mq.size(), n_exp);
        end
    endtask

    initial begin
        test_reset();
        flush(2);
        test_alu();
        flush(2);
        test_load_byte();
        flush(2);
        test_load_half_word();
        flush(2);
        test_store();
        flush(2);
        test_spurious_resp();
        flush(3);
        test_random(400);
        flush(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
